// File: rtl/esi_manifest_pkg.sv
// Shared types and constants for the ESI manifest reader: command opcodes,
// controller states and response word geometry.
package esi_manifest_pkg;

  localparam int WORD_BYTES = 8;
  localparam int RSP_W      = 64;

  typedef enum logic {
    OP_INFO = 1'b0,
    OP_READ = 1'b1
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INFO  = 3'd1,
    ST_FETCH = 3'd2,
    ST_PACK  = 3'd3,
    ST_SEND  = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

endpackage

// File: rtl/esi_manifest_reader_if.sv
// Host-side command and response channels of the manifest reader.
interface esi_manifest_reader_if;

  // Both channels use valid/ready: a transfer happens on a clock edge where
  // valid and ready are both high; once valid rises, the sender holds valid
  // and all payload signals stable until that transfer, and valid never
  // depends on ready.
  logic                           cmd_valid;
  logic                           cmd_ready;
  esi_manifest_pkg::op_e          cmd_op;
  logic [31:0]                    cmd_offset;
  logic [15:0]                    cmd_count;

  logic                           rsp_valid;
  logic                           rsp_ready;
  logic [esi_manifest_pkg::RSP_W-1:0] rsp_data;
  logic                           rsp_last;
  logic                           rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_offset, cmd_count, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_last, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_offset, cmd_count, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_last, rsp_err
  );

endinterface

// File: rtl/esi_manifest_packer.sv
// Byte-lane assembler: each ROM byte arrives one cycle after its strobe and is
// written into the lane that was addressed; lanes never strobed stay zero.
module esi_manifest_packer
  import esi_manifest_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             strobe,
  input  logic [2:0]       lane,
  input  logic [7:0]       rom_data,
  output logic [RSP_W-1:0] word
);

  logic       cap_en;
  logic [2:0] cap_lane;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_en   <= 1'b0;
      cap_lane <= 3'd0;
      word     <= '0;
    end else begin
      cap_en   <= strobe;
      cap_lane <= lane;
      // Clearing at word start is what zeroes lanes past the manifest end.
      if (clear)
        word <= '0;
      else if (cap_en)
        word[{cap_lane, 3'b000} +: 8] <= rom_data;
    end
  end

endmodule

// File: rtl/esi_manifest_reader.sv
// Manifest read controller: decodes INFO/READ commands, walks the ROM one byte
// per cycle, and returns packed 64-bit words with last/err flags.
module esi_manifest_reader
  import esi_manifest_pkg::*;
#(
  parameter int unsigned MANIFEST_SIZE = 0,
  parameter int unsigned ESI_VERSION   = 1,
  parameter int          ADDR_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  esi_manifest_reader_if.slave bus,
  output logic              rom_rd_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output state_e            dbg_state
);

  localparam logic [ADDR_W:0] SIZE_A  = (ADDR_W+1)'(MANIFEST_SIZE);
  localparam logic [32:0]     SIZE_33 = 33'(MANIFEST_SIZE);

  state_e            state, state_nxt;
  logic [ADDR_W:0]   baddr;
  logic [15:0]       words_rem;
  logic [32:0]       b0;
  logic              accept, bad_read, send_last, rsp_fire, pack_clear;
  logic [RSP_W-1:0]  packed_word;

  assign accept     = bus.cmd_valid && bus.cmd_ready;
  assign b0         = {bus.cmd_offset, 3'b000};
  assign bad_read   = (bus.cmd_count == 16'd0) || (b0 >= SIZE_33);
  assign send_last  = (words_rem == 16'd1) || (baddr >= SIZE_A);
  assign rsp_fire   = bus.rsp_valid && bus.rsp_ready;
  assign pack_clear = accept || ((state == ST_SEND) && rsp_fire);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Word starts are 8-aligned, so the low address bits double as lane index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      baddr     <= '0;
      words_rem <= '0;
    end else if (accept && (bus.cmd_op == OP_READ) && !bad_read) begin
      baddr     <= b0[ADDR_W:0];
      words_rem <= bus.cmd_count;
    end else begin
      if (state == ST_FETCH)
        baddr <= baddr + (ADDR_W+1)'(1);
      if ((state == ST_SEND) && rsp_fire)
        words_rem <= words_rem - 16'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:
        if (accept) begin
          if (bus.cmd_op == OP_INFO) state_nxt = ST_INFO;
          else if (bad_read)         state_nxt = ST_ERR;
          else                       state_nxt = ST_FETCH;
        end
      ST_INFO, ST_ERR:
        if (bus.rsp_ready) state_nxt = ST_IDLE;
      ST_FETCH:
        if (baddr[2:0] == 3'd7) state_nxt = ST_PACK;
      ST_PACK:
        state_nxt = ST_SEND;
      ST_SEND:
        if (bus.rsp_ready) state_nxt = send_last ? ST_IDLE : ST_FETCH;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rom_rd_en     = (state == ST_FETCH) && (baddr < SIZE_A);
    rom_addr      = rom_rd_en ? baddr[ADDR_W-1:0] : '0;
    bus.cmd_ready = (state == ST_IDLE) && rst_n;
    bus.rsp_valid = (state == ST_INFO) || (state == ST_SEND) || (state == ST_ERR);
    bus.rsp_err   = (state == ST_ERR);
    bus.rsp_last  = 1'b0;
    bus.rsp_data  = '0;
    dbg_state     = state;
    unique case (state)
      ST_INFO: begin
        bus.rsp_data = {ESI_VERSION, MANIFEST_SIZE};
        bus.rsp_last = 1'b1;
      end
      ST_ERR:  bus.rsp_last = 1'b1;
      ST_SEND: begin
        bus.rsp_data = packed_word;
        bus.rsp_last = send_last;
      end
      default: ;
    endcase
  end

  esi_manifest_packer u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (pack_clear),
    .strobe   (rom_rd_en),
    .lane     (baddr[2:0]),
    .rom_data (rom_data),
    .word     (packed_word)
  );

endmodule

// File: tb/tb_esi_manifest_reader.sv
// Directed bench for esi_manifest_reader with a 20-byte ROM holding ROM[i]=i.
module tb_esi_manifest_reader;
  import esi_manifest_pkg::*;

  localparam int ADDR_W = 16;
  localparam int SIZE   = 20;
  localparam int VER    = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rom_rd_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data = 8'd0;
  state_e            dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;
  int rom_pulses   = 0;
  int bad_addr     = 0;
  logic [65:0] exp_q[$];

  esi_manifest_reader_if bus();

  esi_manifest_reader #(
    .MANIFEST_SIZE (SIZE),
    .ESI_VERSION   (VER),
    .ADDR_W        (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .rom_rd_en (rom_rd_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset / ROM model ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_rd_en) begin
      rom_data   <= rom_addr[7:0];
      rom_pulses <= rom_pulses + 1;
      if (rom_addr >= 16'(SIZE)) bad_addr <= bad_addr + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [63:0] data, input logic last, input logic err);
    exp_q.push_back({err, last, data});
  endtask

  // ---------------- drivers ----------------
  task automatic send_cmd(input op_e op, input logic [31:0] off, input logic [15:0] cnt);
    int waited = 0;
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = op;
    bus.cmd_offset = off;
    bus.cmd_count  = cnt;
    while (!bus.cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("cmd_accept", 64'(bus.cmd_ready), 64'd1);
    @(negedge clk);
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = op_e'(1'($urandom_range(0, 1)));
    bus.cmd_offset = $urandom;
    bus.cmd_count  = 16'($urandom_range(0, 65535));
  endtask

  task automatic recv_words(input int n, input bit stall);
    for (int w = 0; w < n; w++) begin
      int          waited = 0;
      int          unstable;
      int          p0;
      logic [65:0] exp;
      logic [66:0] snap;
      while (!bus.rsp_valid && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      if (!bus.rsp_valid) begin
        check("rsp_timeout", 64'(bus.rsp_valid), 64'd1);
        return;
      end
      if (exp_q.size() == 0) begin
        check("unexpected_word", bus.rsp_data, 64'd0);
        return;
      end
      exp = exp_q.pop_front();
      check($sformatf("rsp_data_w%0d", w), bus.rsp_data, exp[63:0]);
      check($sformatf("rsp_last_w%0d", w), 64'(bus.rsp_last), 64'(exp[64]));
      check($sformatf("rsp_err_w%0d", w), 64'(bus.rsp_err), 64'(exp[65]));
      if (stall && w == 0) begin
        snap     = {bus.rsp_valid, bus.rsp_err, bus.rsp_last, bus.rsp_data};
        p0       = rom_pulses;
        unstable = 0;
        repeat (50) begin
          @(negedge clk);
          if ({bus.rsp_valid, bus.rsp_err, bus.rsp_last, bus.rsp_data} !== snap) unstable++;
        end
        check("stall_stable", 64'(unstable), 64'd0);
        check("stall_no_rom", 64'(rom_pulses - p0), 64'd0);
        bus.rsp_ready = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int p0;
    int seen;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = OP_INFO;
    bus.cmd_offset = 32'd0;
    bus.cmd_count  = 16'd0;
    bus.rsp_ready  = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_state",     64'(dbg_state), 64'(ST_IDLE));
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    check("rst_rom_rd_en", 64'(rom_rd_en), 64'd0);
    check("rst_rom_addr",  64'(rom_addr), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_data",  bus.rsp_data, 64'd0);
    check("rst_rsp_flags", 64'({bus.rsp_last, bus.rsp_err}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 64'(bus.cmd_ready), 64'd1);

    // INFO
    push_word(64'h00000001_00000014, 1'b1, 1'b0);
    send_cmd(OP_INFO, 32'd0, 16'd0);
    recv_words(1, 1'b0);

    // Full read from 0, count larger than the manifest
    p0 = rom_pulses;
    push_word(64'h07060504_03020100, 1'b0, 1'b0);
    push_word(64'h0F0E0D0C_0B0A0908, 1'b0, 1'b0);
    push_word(64'h00000000_13121110, 1'b1, 1'b0);
    send_cmd(OP_READ, 32'd0, 16'd8);
    recv_words(3, 1'b0);
    check("pulses_off0_cnt8", 64'(rom_pulses - p0), 64'd20);

    // Single word from the middle
    p0 = rom_pulses;
    push_word(64'h0F0E0D0C_0B0A0908, 1'b1, 1'b0);
    send_cmd(OP_READ, 32'd1, 16'd1);
    recv_words(1, 1'b0);
    check("pulses_off1_cnt1", 64'(rom_pulses - p0), 64'd8);

    // Partial tail word
    p0 = rom_pulses;
    push_word(64'h00000000_13121110, 1'b1, 1'b0);
    send_cmd(OP_READ, 32'd2, 16'd8);
    recv_words(1, 1'b0);
    check("pulses_off2_tail", 64'(rom_pulses - p0), 64'd4);

    // Count limit ends stream before manifest end
    push_word(64'h07060504_03020100, 1'b0, 1'b0);
    push_word(64'h0F0E0D0C_0B0A0908, 1'b1, 1'b0);
    send_cmd(OP_READ, 32'd0, 16'd2);
    recv_words(2, 1'b0);

    // Error cases: offset past end, zero count, offset that wraps in 32 bits
    p0 = rom_pulses;
    push_word(64'd0, 1'b1, 1'b1);
    send_cmd(OP_READ, 32'd3, 16'd1);
    recv_words(1, 1'b0);
    push_word(64'd0, 1'b1, 1'b1);
    send_cmd(OP_READ, 32'd0, 16'd0);
    recv_words(1, 1'b0);
    push_word(64'd0, 1'b1, 1'b1);
    send_cmd(OP_READ, 32'h2000_0000, 16'd1);
    recv_words(1, 1'b0);
    check("pulses_err", 64'(rom_pulses - p0), 64'd0);

    // Backpressure on the first word
    bus.rsp_ready = 1'b0;
    push_word(64'h07060504_03020100, 1'b0, 1'b0);
    push_word(64'h0F0E0D0C_0B0A0908, 1'b0, 1'b0);
    push_word(64'h00000000_13121110, 1'b1, 1'b0);
    send_cmd(OP_READ, 32'd0, 16'd8);
    recv_words(3, 1'b1);

    // Reset while fetching the second word
    push_word(64'h07060504_03020100, 1'b0, 1'b0);
    send_cmd(OP_READ, 32'd0, 16'd8);
    recv_words(1, 1'b0);
    repeat (2) @(negedge clk);
    check("mid_state_fetch", 64'(dbg_state), 64'(ST_FETCH));
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_state",     64'(dbg_state), 64'(ST_IDLE));
    check("midrst_rom_rd_en", 64'(rom_rd_en), 64'd0);
    check("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("midrst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.rsp_valid || rom_rd_en) seen++;
    end
    check("midrst_quiet", 64'(seen), 64'd0);
    push_word(64'h00000001_00000014, 1'b1, 1'b0);
    send_cmd(OP_INFO, 32'd5, 16'd3);
    recv_words(1, 1'b0);

    repeat (3) @(negedge clk);
    check("rom_addr_in_range", 64'(bad_addr), 64'd0);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
